// File: rtl/fraction_sequencer.sv
// rtl/fraction_sequencer.sv - harmonic-sum sequencer driving a wavetable ROM and an external fraction multiplier
module fraction_sequencer #(
  parameter int DIVISOR_BITS = 7,
  parameter int ADDR_BITS    = 11,
  parameter int OUT_SHIFT    = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_sample_tick,
  input  logic [ADDR_BITS-1:0]    i_phase,
  input  logic [5:0]              i_harmonic_count,
  input  logic [DIVISOR_BITS-1:0] i_decay,
  output logic [ADDR_BITS-1:0]    o_rom_addr,
  input  logic signed [15:0]      i_rom_data,
  output logic                    o_frac_start,
  output logic                    o_frac_clear,
  output logic [DIVISOR_BITS-1:0] o_frac_multiple,
  output logic signed [15:0]      o_frac_in,
  input  logic                    i_frac_done,
  input  logic signed [31:0]      i_frac_accumulator,
  output logic signed [15:0]      o_sample_out,
  output logic                    o_sample_valid,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam logic [DIVISOR_BITS-1:0] FULL_LEVEL = {DIVISOR_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LOAD,
    START,
    WAIT,
    NEXT,
    OUTPUT
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  // Per-sample copies of the live inputs; the live ports may change mid-sample.
  logic [ADDR_BITS-1:0]      r_phase;
  logic [5:0]                r_count;
  logic [DIVISOR_BITS-1:0]   r_decay;

  // Harmonic index (1-based), current level and running wavetable address.
  logic [6:0]                r_h;
  logic [DIVISOR_BITS-1:0]   r_level;
  logic [ADDR_BITS-1:0]      r_addr_acc;

  // High only in the first WAIT cycle, when frac_done may still be stale.
  logic                      r_wait_first;

  logic [ADDR_BITS-1:0]      r_rom_addr;
  logic signed [15:0]        r_frac_in;
  logic [DIVISOR_BITS-1:0]   r_frac_multiple;
  logic                      r_frac_start;
  logic                      r_frac_clear;
  logic signed [15:0]        r_sample_out;
  logic                      r_sample_valid;
  logic                      r_busy;
  logic                      r_overrun;

  logic [ADDR_BITS-1:0]      w_addr_next;
  logic [DIVISOR_BITS-1:0]   w_level_next;
  logic                      w_last;
  logic signed [31:0]        w_shifted;
  logic signed [15:0]        w_saturated;

  // Address advances by the fundamental phase and wraps naturally at 2^ADDR_BITS.
  assign w_addr_next  = r_addr_acc + r_phase;
  assign w_level_next = (r_level > r_decay) ? (r_level - r_decay) : '0;
  // r_h counts harmonics completed including the one just finished.
  assign w_last       = (r_h == {1'b0, r_count}) || (w_level_next == '0);
  assign w_shifted    = i_frac_accumulator >>> OUT_SHIFT;

  // Clamp the scaled accumulator into the signed 16-bit output range.
  always_comb begin
    w_saturated = w_shifted[15:0];
    if (w_shifted > 32'sd32767) begin
      w_saturated = 16'sh7FFF;
    end else if (w_shifted < -32'sd32768) begin
      w_saturated = 16'sh8000;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_sample_tick) w_next_state = CLEAR;
      CLEAR:   w_next_state = (r_count == 6'd0) ? OUTPUT : FETCH;
      FETCH:   w_next_state = LOAD;
      LOAD:    w_next_state = START;
      START:   w_next_state = WAIT;
      WAIT:    if (!r_wait_first && i_frac_done) w_next_state = NEXT;
      NEXT:    w_next_state = w_last ? OUTPUT : FETCH;
      OUTPUT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered pulses, busy/overrun flags and the per-harmonic datapath.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase         <= '0;
      r_count         <= '0;
      r_decay         <= '0;
      r_h             <= '0;
      r_level         <= '0;
      r_addr_acc      <= '0;
      r_wait_first    <= 1'b0;
      r_rom_addr      <= '0;
      r_frac_in       <= '0;
      r_frac_multiple <= '0;
      r_frac_start    <= 1'b0;
      r_frac_clear    <= 1'b0;
      r_sample_out    <= '0;
      r_sample_valid  <= 1'b0;
      r_busy          <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      // Pulses are flopped from the next state so each one coincides with its state.
      r_frac_start   <= (w_next_state == START);
      r_frac_clear   <= (w_next_state == CLEAR);
      r_sample_valid <= (w_next_state == OUTPUT);
      r_busy         <= (w_next_state != IDLE);
      r_wait_first   <= (r_state == START);

      if (i_sample_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_sample_tick) begin
            r_phase    <= i_phase;
            r_count    <= i_harmonic_count;
            r_decay    <= i_decay;
            r_h        <= 7'd1;
            r_addr_acc <= i_phase;
            r_level    <= FULL_LEVEL;
          end
        end
        CLEAR: begin
          if (r_count != 6'd0) begin
            r_rom_addr <= r_addr_acc;
          end else begin
            // The accumulator is being cleared this very cycle, so the mix is zero.
            r_sample_out <= '0;
          end
        end
        LOAD: begin
          r_frac_in       <= i_rom_data;
          r_frac_multiple <= r_level;
        end
        NEXT: begin
          r_addr_acc <= w_addr_next;
          r_level    <= w_level_next;
          r_h        <= r_h + 7'd1;
          if (w_last) begin
            r_sample_out <= w_saturated;
          end else begin
            r_rom_addr <= w_addr_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rom_addr      = r_rom_addr;
  assign o_frac_start    = r_frac_start;
  assign o_frac_clear    = r_frac_clear;
  assign o_frac_multiple = r_frac_multiple;
  assign o_frac_in       = r_frac_in;
  assign o_sample_out    = r_sample_out;
  assign o_sample_valid  = r_sample_valid;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_fraction_sequencer.sv
// tb/tb_fraction_sequencer.sv - self-checking bench for fraction_sequencer
module tb_fraction_sequencer;

  logic                clk = 1'b0;
  logic                i_reset;
  logic                i_sample_tick;
  logic [10:0]         i_phase;
  logic [5:0]          i_harmonic_count;
  logic [6:0]          i_decay;
  logic [10:0]         o_rom_addr;
  logic signed [15:0]  i_rom_data;
  logic                o_frac_start;
  logic                o_frac_clear;
  logic [6:0]          o_frac_multiple;
  logic signed [15:0]  o_frac_in;
  logic                i_frac_done;
  logic signed [31:0]  i_frac_accumulator;
  logic signed [15:0]  o_sample_out;
  logic                o_sample_valid;
  logic                o_busy;
  logic                o_overrun;

  always #5 clk = ~clk;

  fraction_sequencer #(.DIVISOR_BITS(7), .ADDR_BITS(11), .OUT_SHIFT(4)) dut (
    .i_clock            (clk),
    .i_reset            (i_reset),
    .i_sample_tick      (i_sample_tick),
    .i_phase            (i_phase),
    .i_harmonic_count   (i_harmonic_count),
    .i_decay            (i_decay),
    .o_rom_addr         (o_rom_addr),
    .i_rom_data         (i_rom_data),
    .o_frac_start       (o_frac_start),
    .o_frac_clear       (o_frac_clear),
    .o_frac_multiple    (o_frac_multiple),
    .o_frac_in          (o_frac_in),
    .i_frac_done        (i_frac_done),
    .i_frac_accumulator (i_frac_accumulator),
    .o_sample_out       (o_sample_out),
    .o_sample_valid     (o_sample_valid),
    .o_busy             (o_busy),
    .o_overrun          (o_overrun)
  );

  // Wavetable ROM: one cycle read latency.
  logic signed [15:0] rom_mem [0:2047];
  always @(posedge clk) i_rom_data <= rom_mem[o_rom_addr];

  // Fraction multiplier: done stays stale for one cycle after start, then
  // drops for mul_lat cycles and adds (in*multiple)>>>7 to the running sum.
  int   mul_lat = 1;
  int   m_acc, m_prod, m_cnt;
  logic m_done, m_pend;
  logic force_en = 1'b0;
  logic signed [31:0] force_val = 32'sd0;
  always @(posedge clk) begin
    if (i_reset) begin
      m_acc <= 0; m_prod <= 0; m_cnt <= 0; m_done <= 1'b1; m_pend <= 1'b0;
    end else begin
      if (o_frac_clear) m_acc <= 0;
      if (o_frac_start) begin
        m_pend <= 1'b1;
        m_prod <= (int'(o_frac_in) * int'(o_frac_multiple)) >>> 7;
      end else if (m_pend) begin
        m_pend <= 1'b0; m_done <= 1'b0; m_cnt <= mul_lat;
      end else if (!m_done) begin
        if (m_cnt <= 1) begin
          m_done <= 1'b1; m_acc <= m_acc + m_prod;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end
  assign i_frac_done        = m_done;
  assign i_frac_accumulator = force_en ? force_val : m_acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: harmonic h reads address h*phase mod 2048 at a level that
  // starts full-scale and falls by decay per harmonic, stopping at zero.
  int exp_addr[$];
  int exp_level[$];
  function automatic int ref_model(input int p, input int n, input int d);
    int acc, lvl, a, s;
    exp_addr.delete(); exp_level.delete();
    acc = 0; lvl = 127;
    for (int h = 1; h <= n; h++) begin
      a = (p * h) % 2048;
      exp_addr.push_back(a);
      exp_level.push_back(lvl);
      acc += (int'(rom_mem[a]) * lvl) >>> 7;
      lvl = (lvl > d) ? lvl - d : 0;
      if (lvl == 0) break;
    end
    s = acc >>> 4;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  int g_starts, g_clears, g_multi, g_busyerr, g_timeout, g_out;
  int obs_addr[$];
  int obs_level[$];

  // Observe from the current negedge until sample_valid; optionally pulse a tick at cycle inject_cycle.
  task automatic collect(input int inject_cycle);
    int  cyc;
    bit  seen;
    g_starts = 0; g_clears = 0; g_multi = 0; g_busyerr = 0;
    obs_addr.delete(); obs_level.delete();
    cyc = 0; seen = 0;
    while (!seen && cyc < 4000) begin
      i_sample_tick = (cyc == inject_cycle);
      if (o_frac_start) begin
        g_starts++;
        obs_addr.push_back(int'(o_rom_addr));
        obs_level.push_back(int'(o_frac_multiple));
      end
      if (o_frac_clear) g_clears++;
      if (int'(o_frac_start) + int'(o_frac_clear) + int'(o_sample_valid) > 1) g_multi++;
      if (!o_busy) g_busyerr++;
      if (o_sample_valid) begin
        g_out = int'(o_sample_out);
        seen  = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    i_sample_tick = 1'b0;
    g_timeout = seen ? 0 : 1;
  endtask

  task automatic run_sample(input int p, input int n, input int d, input int lat, input int inject);
    mul_lat          = lat;
    i_phase          = 11'(p);
    i_harmonic_count = 6'(n);
    i_decay          = 7'(d);
    i_sample_tick    = 1'b1;
    @(negedge clk);
    i_sample_tick    = 1'b0;
    i_phase          = 11'($urandom);
    i_harmonic_count = 6'($urandom);
    i_decay          = 7'($urandom);
    collect(inject);
  endtask

  task automatic check_against(input string name, input int exp_out);
    check({name, " timeout"}, g_timeout, 0);
    check({name, " clears"}, g_clears, 1);
    check({name, " overlap"}, g_multi, 0);
    check({name, " busy_gap"}, g_busyerr, 0);
    check({name, " starts"}, g_starts, exp_addr.size());
    check({name, " out"}, g_out, exp_out);
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s level[%0d]", name, i), obs_level[i], exp_level[i]);
    end
    @(negedge clk);
    check({name, " valid_pulse"}, int'(o_sample_valid), 0);
    check({name, " idle_busy"}, int'(o_busy), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
  endtask

  typedef struct {
    int phase; int count; int decay; int lat; int exp_starts; int exp_out;
  } vec_t;
  vec_t tbl [6];

  int e, cyc, nv, d_r;
  int sat_in  [4];
  int sat_exp [4];

  initial begin
    tbl[0] = '{100,    1,  0,   1, 1, 992};
    tbl[1] = '{'h7F0,  3,  0,   2, 3, 186};
    tbl[2] = '{'h200,  10, 50,  3, 3, -903};
    tbl[3] = '{5,      0,  3,   1, 0, 0};
    tbl[4] = '{0,      4,  0,   2, 4, -8128};
    tbl[5] = '{'h123,  5,  127, 1, 1, 124};

    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
    rom_mem[100]   = 16'sd16000;
    rom_mem['h7F0] = 16'sd1000;
    rom_mem['h7E0] = 16'sd1000;
    rom_mem['h7D0] = 16'sd1000;
    rom_mem['h200] = -16'sd8000;
    rom_mem['h400] = -16'sd8000;
    rom_mem['h600] = -16'sd8000;
    rom_mem[0]     = -16'sd32768;
    rom_mem['h123] = 16'sd2000;

    i_reset = 1'b1; i_sample_tick = 1'b0;
    i_phase = '0; i_harmonic_count = '0; i_decay = '0;
    do_reset();

    check("rst rom_addr", int'(o_rom_addr), 0);
    check("rst frac_in", int'(o_frac_in), 0);
    check("rst frac_multiple", int'(o_frac_multiple), 0);
    check("rst sample_out", int'(o_sample_out), 0);
    check("rst frac_start", int'(o_frac_start), 0);
    check("rst frac_clear", int'(o_frac_clear), 0);
    check("rst sample_valid", int'(o_sample_valid), 0);
    check("rst busy", int'(o_busy), 0);
    check("rst overrun", int'(o_overrun), 0);

    for (int i = 0; i < 6; i++) begin
      e = ref_model(tbl[i].phase, tbl[i].count, tbl[i].decay);
      run_sample(tbl[i].phase, tbl[i].count, tbl[i].decay, tbl[i].lat, -1);
      check($sformatf("tbl%0d starts_const", i), g_starts, tbl[i].exp_starts);
      check($sformatf("tbl%0d out_const", i), g_out, tbl[i].exp_out);
      check_against($sformatf("tbl%0d", i), e);
    end

    for (int i = 0; i < 30; i++) begin
      int p, n, lat;
      p   = $urandom_range(0, 2047);
      n   = $urandom_range(0, 63);
      d_r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 127);
      lat = $urandom_range(1, 4);
      e = ref_model(p, n, d_r);
      run_sample(p, n, d_r, lat, -1);
      check_against($sformatf("rnd%0d", i), e);
    end

    sat_in[0] = 32'h7FFF_0000; sat_exp[0] = 32767;
    sat_in[1] = 32'h8000_0000; sat_exp[1] = -32768;
    sat_in[2] = 32'h0007_FFF0; sat_exp[2] = 32767;
    sat_in[3] = 32'hFFF8_0000; sat_exp[3] = -32768;
    force_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      force_val = sat_in[i];
      e = ref_model(1, 1, 0);
      run_sample(1, 1, 0, 1, -1);
      check_against($sformatf("sat%0d", i), sat_exp[i]);
    end
    force_val = 32'sh0008_0000;
    e = ref_model(1, 1, 0);
    run_sample(1, 1, 0, 1, -1);
    check_against("sat_edge", 32767);
    force_en = 1'b0;

    check("pre_ovr overrun", int'(o_overrun), 0);
    e = ref_model('h0AB, 6, 3);
    run_sample('h0AB, 6, 3, 2, 3);
    check_against("ovr", e);
    check("ovr set", int'(o_overrun), 1);
    e = ref_model('h311, 2, 9);
    run_sample('h311, 2, 9, 1, -1);
    check_against("ovr_after", e);
    check("ovr sticky", int'(o_overrun), 1);

    mul_lat = 4;
    i_phase = 11'h155; i_harmonic_count = 6'd5; i_decay = 7'd1;
    i_sample_tick = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    cyc = 0;
    while (!o_frac_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rstw start_seen", int'(o_frac_start), 1);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("rstw busy", int'(o_busy), 0);
    check("rstw valid", int'(o_sample_valid), 0);
    check("rstw overrun", int'(o_overrun), 0);
    check("rstw rom_addr", int'(o_rom_addr), 0);
    check("rstw frac_multiple", int'(o_frac_multiple), 0);
    check("rstw frac_in", int'(o_frac_in), 0);
    i_reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_sample_valid || o_busy) nv++;
    end
    check("rstw no_resume", nv, 0);
    e = ref_model(100, 1, 0);
    run_sample(100, 1, 0, 2, -1);
    check_against("post_rst", e);
    check("post_rst const", g_out, 992);

    e = ref_model(100, 1, 0);
    run_sample(100, 1, 0, 2, -1);
    check("r17 first out", g_out, e);
    check("r17 first timeout", g_timeout, 0);
    i_phase = 11'h200; i_harmonic_count = 6'd10; i_decay = 7'd50;
    i_sample_tick = 1'b1;
    @(negedge clk);
    check("r17 overrun", int'(o_overrun), 1);
    check("r17 dropped", int'(o_busy), 0);
    @(negedge clk);
    i_sample_tick = 1'b0;
    i_phase = 11'($urandom); i_harmonic_count = 6'($urandom); i_decay = 7'($urandom);
    check("r17 accept busy", int'(o_busy), 1);
    check("r17 accept clear", int'(o_frac_clear), 1);
    e = ref_model('h200, 10, 50);
    collect(-1);
    check_against("r17 second", e);
    check("r17 second const", g_out, -903);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fraction_sequencer.md
FRACTION_SEQUENCER -- requirements
Module: fraction_sequencer

Interface
REQ-001 Parameter DIVISOR_BITS, default 7, SHALL set the width of frac_multiple and decay; full-scale level is 2^DIVISOR_BITS-1.
REQ-002 Parameter ADDR_BITS, default 11, SHALL set the wavetable address and phase width.
REQ-003 Parameter OUT_SHIFT, default 4, SHALL set the right shift applied to frac_accumulator before output saturation.
REQ-004 The block has one clock; reset is synchronous and active-high.
REQ-005 Port list, in order:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle pulse starting a new output sample
- phase  in  ADDR_BITS  fundamental phase for this sample
- harmonic_count  in  6  number of harmonics to sum, 0..63
- decay  in  DIVISOR_BITS  level decrement per harmonic
- rom_addr  out  ADDR_BITS  wavetable address
- rom_data  in  16 signed  wavetable word, valid one cycle after rom_addr
- frac_start  out  1  start pulse to fraction multiplier
- frac_clear  out  1  accumulator clear pulse
- frac_multiple  out  DIVISOR_BITS  current harmonic level
- frac_in  out  16 signed  operand to multiplier
- frac_done  in  1  multiplier idle/complete
- frac_accumulator  in  32 signed  multiplier running sum
- sample_out  out  16 signed  saturated mixed sample
- sample_valid  out  1  one-cycle pulse, sample_out updated
- busy  out  1  high from accepted sample_tick to sample_valid
- overrun  out  1  sticky: sample_tick arrived while busy

Function
REQ-006 FSM states SHALL be IDLE, CLEAR, FETCH, LOAD, START, WAIT, NEXT, OUTPUT.
REQ-007 IDLE: on sample_tick SHALL latch phase, harmonic_count, decay; set h=1, addr_acc=phase, level=2^DIVISOR_BITS-1; go CLEAR.
REQ-008 CLEAR: frac_clear high exactly one cycle; harmonic_count==0 -> OUTPUT, else FETCH.
REQ-009 FETCH: rom_addr=addr_acc; go LOAD.
REQ-010 LOAD: register rom_data into frac_in and level into frac_multiple; go START.
REQ-011 START: frac_start high exactly one cycle; go WAIT.
REQ-012 WAIT: frac_done SHALL be ignored in the first WAIT cycle; thereafter frac_done high -> NEXT.
REQ-013 NEXT: addr_acc+=latched phase (modulo 2^ADDR_BITS); level=max(level-decay,0); h+=1; if h==latched count or new level==0 -> OUTPUT, else FETCH.
REQ-014 OUTPUT: sample_out=saturate16(frac_accumulator>>>OUT_SHIFT, arithmetic shift), clamp to +32767/-32768; sample_valid high one cycle; go IDLE.
REQ-015 frac_start, frac_clear, sample_valid SHALL be registered single-cycle pulses, never simultaneous.
REQ-016 sample_tick outside IDLE SHALL be dropped and set overrun; overrun clears only on reset.
REQ-017 sample_tick coincident with OUTPUT SHALL count as overrun; sample_tick in the IDLE cycle following OUTPUT SHALL be accepted.
REQ-018 Latched inputs SHALL be stable for the whole sample; live input changes mid-sample have no effect.
REQ-019 busy SHALL be high in every state except IDLE; sample_valid cycle counts busy.
REQ-020 Per-harmonic latency SHALL be 4 cycles plus multiplier time (FETCH, LOAD, START, NEXT + WAIT).

Reset
REQ-021 On reset: state IDLE; rom_addr, frac_in, frac_multiple, sample_out = 0; frac_start, frac_clear, sample_valid, busy, overrun = 0; internal h, level, addr_acc = 0.
REQ-022 Reset asserted mid-sample SHALL abort immediately without sample_valid; the next sample's CLEAR guarantees a clean accumulator.

Verification
V-1 Reset -> all outputs 0, busy 0; first tick with phase=100, count=1, decay=0, rom_data=16000 -> one frac_start, frac_multiple=127, sample_valid once, sample_out=(16000*127>>7)>>>4=992.
V-2 count=3, phase=0x7F0, ADDR_BITS=11 -> rom_addr sequence 0x7F0, 0x7E0, 0x7D0 (wrap) and three frac_start pulses.
V-3 count=10, decay=50 -> levels 127, 77, 27; terminates after 3rd harmonic (level 0), sample_valid once.
V-4 count=0 -> frac_clear then sample_valid with no frac_start; sample_out = 0 with model accumulator held 0.
V-5 frac_accumulator forced 0x7FFF_0000 and 0x8000_0000 at OUTPUT -> sample_out 32767 and -32768.
V-6 second sample_tick while busy -> ignored, overrun=1 sticky; reset asserted mid-WAIT -> IDLE next cycle, no sample_valid, overrun=0.
